// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
//
// Memory-side responder that sits behind the i-cache/d-cache arbiter. It takes
// one whole-cacheline read or write from the arbitrated cache port and turns
// it into a fixed-length burst of BEATS beats on the physical memory bus. When
// the burst is finished it raises resp_o for one cycle, and the arbiter uses
// that pulse to release its grant.
//
// Handshake semantics:
//   Cache side : read_i / write_i act as a level "valid". The requester holds
//                the request, along with address_i and line_i, until resp_o
//                pulses. The adaptor samples them only in IDLE. resp_o is the
//                single-cycle "done" and line_o is valid while it is high.
//                Requests present during DONE are ignored, so a request that
//                is still held at that point cannot relaunch until IDLE.
//   Memory side: read_o / write_o stay high for the whole burst. resp_i is a
//                per-beat strobe: each rising edge where it is high moves one
//                beat. burst_i is captured on that edge for reads, and
//                burst_o is presented throughout for writes. Low cycles on
//                resp_i are stalls.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   read_i       cacheline read request (held until resp_o)
//   write_i      cacheline write request (held until resp_o)
//   address_i    request byte address
//   line_i       cacheline write data
//   line_o       last completed read line (valid with resp_o)
//   resp_o       one-cycle completion pulse
//   read_o       memory burst read request
//   write_o      memory burst write request
//   address_o    line-aligned burst address
//   burst_o      write beat data
//   burst_i      read beat data
//   resp_i       memory beat strobe
//   state_o      debug view of the FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   read_i,
   input  logic                   write_i,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   output logic                   resp_o,
   output logic                   read_o,
   output logic                   write_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic [BURST_WIDTH-1:0] burst_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   input  logic                   resp_i,
   output logic [1:0]             state_o
);

   localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Masking the address, rather than slicing off its low bits, clears the
   // in-line byte offset and leaves every input bit in use.
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   // A line viewed as an array of beats. Beat 0 is the lowest-order slice.
   typedef logic [BEATS-1:0][BURST_WIDTH-1:0] beats_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   beats_t                  wbuf_q,  wbuf_d;   // write line captured at launch
   beats_t                  rbuf_q,  rbuf_d;   // read beats being assembled
   beats_t                  line_q,  line_d;   // last completed read line

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
         line_q  <= line_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      line_d  = line_q;

      unique case (state_q)
         IDLE: begin
            // Write wins if both requests are asserted, so an illegal
            // double request still runs a single transaction to completion.
            if (write_i) begin
               wbuf_d  = line_i;
               addr_d  = address_i & LINE_MASK;
               cnt_d   = '0;
               state_d = WRITE;
            end else if (read_i) begin
               addr_d  = address_i & LINE_MASK;
               cnt_d   = '0;
               state_d = READ;
            end
         end

         READ: begin
            if (resp_i) begin
               rbuf_d[cnt_q] = burst_i;
               if (cnt_q == LAST_BEAT) begin
                  // Publish the whole line only when its final beat lands,
                  // so line_o keeps the previous line for the whole burst.
                  line_d  = rbuf_d;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         WRITE: begin
            if (resp_i) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         DONE: begin
            // Return unconditionally. A held request is not looked at until
            // the next IDLE cycle.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from state or driven straight from registers, so there
   // is no path from the request inputs to the memory side.
   // ------------------------------------------------------------------------
   assign read_o    = (state_q == READ);
   assign write_o   = (state_q == WRITE);
   assign resp_o    = (state_q == DONE);
   assign address_o = addr_q;
   assign line_o    = line_q;
   assign burst_o   = (state_q == WRITE) ? wbuf_q[cnt_q] : '0;
   assign state_o   = state_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Bench for cacheline_adaptor. A table of read/write transactions is applied
// in a loop. Each record gives the request, the line data (write data, or the
// beats that memory returns), a resp_i stall pattern and the expected aligned
// address. Hand-written sequences cover reset, spurious strobes, a request
// held after completion, reset in the middle of a burst and a simultaneous
// read+write. A scoreboard queues the expected read lines and write beats
// when stimulus is driven and pops them when the DUT produces output.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

   localparam int LW = 256;
   localparam int BW = 64;
   localparam int AW = 32;

   // ------------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst;
   logic          read_i, write_i, resp_i;
   logic [AW-1:0] address_i;
   logic [LW-1:0] line_i;
   logic [BW-1:0] burst_i;
   logic [LW-1:0] line_o;
   logic          resp_o, read_o, write_o;
   logic [AW-1:0] address_o;
   logic [BW-1:0] burst_o;
   logic [1:0]    state_o;

   always #5 clk = ~clk;

   cacheline_adaptor #(
      .LINE_WIDTH (LW),
      .BURST_WIDTH(BW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .read_i   (read_i),
      .write_i  (write_i),
      .address_i(address_i),
      .line_i   (line_i),
      .line_o   (line_o),
      .resp_o   (resp_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .address_o(address_o),
      .burst_o  (burst_o),
      .burst_i  (burst_i),
      .resp_i   (resp_i),
      .state_o  (state_o)
   );

   // ------------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------------
   int            checks = 0;
   int            errors = 0;
   logic [LW-1:0] exp_line_q[$];
   logic [BW-1:0] exp_beat_q[$];
   logic [LW-1:0] last_line;

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      logic [15:0]   pat;       // resp_i per cycle, LSB first
      int            pat_len;   // resp_i held at 1 once the pattern is used up
      logic [AW-1:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   // ------------------------------------------------------------------------
   // Helpers. Inputs are driven and outputs sampled at the falling edge.
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int k = 0; k < LW / 32; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   // One complete transaction. It starts at a falling edge with the DUT idle
   // and ends in the IDLE cycle after DONE.
   task automatic do_txn(input bit is_wr, input bit also_rd, input bit hold,
                         input logic [AW-1:0] addr, input logic [LW-1:0] data,
                         input logic [15:0] pat, input int pat_len,
                         input logic [AW-1:0] exp_addr);
      int            beats;
      int            cyc;
      bit            r;
      logic [BW-1:0] b;

      address_i = addr;
      line_i    = is_wr ? data : rand_line();
      read_i    = !is_wr || also_rd;
      write_i   = is_wr;
      if (is_wr) begin
         for (int k = 0; k < LW / BW; k++) exp_beat_q.push_back(data[BW*k +: BW]);
      end else begin
         exp_line_q.push_back(data);
      end
      step();
      chk("launch_read_o", read_o, !is_wr);
      chk("launch_write_o", write_o, is_wr);
      chk("launch_address_o", address_o, exp_addr);

      // Change the upstream inputs mid-burst. The transaction must not see it.
      if (!hold) begin
         read_i    = 1'b0;
         write_i   = 1'b0;
         address_i = ~addr;
         line_i    = ~data;
      end

      beats = 0;
      cyc   = 0;
      while (beats < LW / BW && cyc < 40) begin
         r       = (cyc < pat_len) ? pat[cyc] : 1'b1;
         resp_i  = r;
         burst_i = is_wr ? BW'($urandom) : data[BW*beats +: BW];
         chk("busy_strobe", is_wr ? write_o : read_o, 1);
         chk("busy_resp_o", resp_o, 0);
         if (is_wr && r) begin
            b = exp_beat_q.pop_front();
            chk("burst_o", burst_o, b);
         end
         step();
         cyc++;
         if (r) beats++;
      end
      if (beats < LW / BW) chk("burst_timeout_beats", beats, LW / BW);
      resp_i = 1'b0;

      // DONE cycle
      chk("done_resp_o", resp_o, 1);
      chk("done_read_o", read_o, 0);
      chk("done_write_o", write_o, 0);
      chk("done_state_o", state_o, 2'd3);
      chk("done_address_o", address_o, exp_addr);
      if (is_wr) begin
         chk("write_keeps_line_o", line_o, last_line);
      end else begin
         chk("read_line_o", line_o, exp_line_q.pop_front());
         last_line = data;
      end
      step();

      // IDLE cycle. No second pulse and no memory request yet.
      chk("idle_resp_o", resp_o, 0);
      chk("idle_read_o", read_o, 0);
      chk("idle_write_o", write_o, 0);
      chk("idle_line_o_held", line_o, last_line);
   endtask

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [LW-1:0] l_a;
      logic [LW-1:0] l_b;
      logic [LW-1:0] l_c;

      rst       = 1'b1;
      read_i    = 1'b0;
      write_i   = 1'b0;
      resp_i    = 1'b0;
      address_i = '0;
      line_i    = '0;
      burst_i   = '0;
      last_line = '0;

      l_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      l_b = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

      vecs[0] = '{1'b0, 32'h0000_1234, l_a, 16'h0000, 0, 32'h0000_1220};
      vecs[1] = '{1'b0, 32'h0000_1234, l_a, 16'b1101001, 7, 32'h0000_1220};
      vecs[2] = '{1'b1, 32'h8000_003F, l_b, 16'h0000, 0, 32'h8000_0020};
      vecs[3] = '{1'b0, 32'hFFFF_FFFF, rand_line(), 16'b01010110, 8, 32'hFFFF_FFE0};
      vecs[4] = '{1'b1, 32'h0000_0000, rand_line(), 16'b0110, 4, 32'h0000_0000};
      vecs[5] = '{1'b0, 32'h1357_9BDF, rand_line(), 16'h0000, 0, 32'h1357_9BC0};

      // Reset state
      step();
      step();
      chk("rst_resp_o", resp_o, 0);
      chk("rst_read_o", read_o, 0);
      chk("rst_write_o", write_o, 0);
      chk("rst_address_o", address_o, 0);
      chk("rst_burst_o", burst_o, 0);
      chk("rst_line_o", line_o, 0);
      chk("rst_state_o", state_o, 2'd0);
      rst = 1'b0;
      step();

      // Spurious strobes in IDLE
      for (int i = 0; i < 6; i++) begin
         resp_i  = i[0];
         burst_i = BW'($urandom);
         step();
         chk("spurious_state_o", state_o, 2'd0);
         chk("spurious_read_o", read_o, 0);
         chk("spurious_resp_o", resp_o, 0);
      end
      resp_i = 1'b0;

      // Table-driven transactions, back to back
      for (int i = 0; i < 6; i++) begin
         do_txn(vecs[i].is_wr, 1'b0, 1'b0, vecs[i].addr, vecs[i].data,
                vecs[i].pat, vecs[i].pat_len, vecs[i].exp_addr);
      end

      // Request held through DONE: exactly one relaunch from the next IDLE
      l_a = rand_line();
      l_b = rand_line();
      do_txn(1'b0, 1'b0, 1'b1, 32'h0000_4010, l_a, 16'h0000, 0, 32'h0000_4000);
      do_txn(1'b0, 1'b0, 1'b0, 32'h0000_4010, l_b, 16'b101, 3, 32'h0000_4000);
      step();
      chk("held_no_extra_launch", read_o, 0);

      // Reset after two beats of a read
      l_c       = rand_line();
      read_i    = 1'b1;
      address_i = 32'h0000_2040;
      step();
      read_i  = 1'b0;
      resp_i  = 1'b1;
      burst_i = BW'($urandom);
      step();
      burst_i = BW'($urandom);
      step();
      resp_i = 1'b0;
      rst    = 1'b1;
      step();
      chk("midrst_read_o", read_o, 0);
      chk("midrst_resp_o", resp_o, 0);
      chk("midrst_state_o", state_o, 2'd0);
      chk("midrst_line_o", line_o, 0);
      chk("midrst_address_o", address_o, 0);
      rst       = 1'b0;
      last_line = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("postrst_resp_o", resp_o, 0);
         chk("postrst_read_o", read_o, 0);
      end
      do_txn(1'b0, 1'b0, 1'b0, 32'h0000_2040, l_c, 16'h0000, 0, 32'h0000_2040);

      // Simultaneous read+write: the write path must be taken
      $display("note: driving illegal simultaneous read_i/write_i request");
      do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0888, rand_line(), 16'b011, 3, 32'h0000_0880);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
